// File: rtl/pipe_ctrl_pkg.sv
// Shared definitions for the pipeline control unit: stall encoding, stage
// indices, FSM state encoding and exception bit positions.
package pipe_ctrl_pkg;

  localparam logic STOP    = 1'b1;
  localparam logic NO_STOP = 1'b0;

  localparam int STG_PC  = 0;
  localparam int STG_IF  = 1;
  localparam int STG_ID  = 2;
  localparam int STG_EX  = 3;
  localparam int STG_MEM = 4;
  localparam int STG_WB  = 5;
  localparam int STALL_W = 6;

  localparam int EXC_W   = 32;
  localparam int CAUSE_W = 5;
  localparam int CNT_W   = 4;

  localparam int EXC_INSTR_MISALIGN = 0;
  localparam int EXC_INSTR_FAULT    = 1;
  localparam int EXC_ILLEGAL_INSTR  = 2;
  localparam int EXC_BREAKPOINT     = 3;
  localparam int EXC_LOAD_MISALIGN  = 4;
  localparam int EXC_LOAD_FAULT     = 5;
  localparam int EXC_STORE_MISALIGN = 6;
  localparam int EXC_STORE_FAULT    = 7;
  localparam int EXC_ECALL_U        = 8;
  localparam int EXC_ECALL_S        = 9;
  localparam int EXC_ECALL_M        = 11;

  typedef enum logic [1:0] {
    ST_IDLE     = 2'd0,
    ST_FLUSH    = 2'd1,
    ST_REDIRECT = 2'd2
  } state_e;

  // Stall vector that stops every stage up to and including stg; the first
  // NO_STOP stage above it receives a bubble.
  function automatic logic [STALL_W-1:0] stall_upto(input int stg);
    logic [STALL_W-1:0] v;
    for (int i = 0; i < STALL_W; i++) begin
      v[i] = (i <= stg) ? STOP : NO_STOP;
    end
    return v;
  endfunction

endpackage

// File: rtl/pipe_ctrl_cause_enc.sv
// Lowest-set-bit encoder: maps the commit-stage exception bitmask to the
// index of its highest-priority (lowest numbered) cause.
module pipe_ctrl_cause_enc
  import pipe_ctrl_pkg::*;
(
  input  logic [EXC_W-1:0]   exc_i,
  output logic [CAUSE_W-1:0] cause_o
);

  // Descending scan so the lowest set bit is the last one written.
  always_comb begin
    cause_o = '0;
    for (int i = EXC_W - 1; i >= 0; i--) begin
      if (exc_i[i]) cause_o = CAUSE_W'(i);
    end
  end

endmodule

// File: rtl/pipe_ctrl.sv
// Pipeline control: stall request merge plus trap/mret flush-and-redirect FSM.
// Optional performance counters are enabled by defining PIPE_CTRL_PERF_CNT_EN.
module pipe_ctrl
  import pipe_ctrl_pkg::*;
#(
  parameter int FLUSH_CYCLES = 1,
  parameter int XLEN         = 32
) (
  input  logic               clk_i,
  input  logic               n_rst_i,
  input  logic               stallreq_if_i,
  input  logic               stallreq_id_i,
  input  logic               stallreq_ex_i,
  input  logic               stallreq_mem_i,
  input  logic [EXC_W-1:0]   exception_i,
  input  logic               mret_i,
  input  logic [XLEN-1:0]    mtvec_i,
  input  logic [XLEN-1:0]    mepc_i,
  input  logic               pc_ack_i,
  output logic [STALL_W-1:0] stall_o,
  output logic               flush_o,
  output logic               new_pc_valid_o,
  output logic [XLEN-1:0]    new_pc_o,
  output logic               trap_o,
`ifdef PIPE_CTRL_PERF_CNT_EN
  output logic [31:0]        stall_cycles_o,
  output logic [31:0]        flush_cycles_o,
`endif
  output logic [CAUSE_W-1:0] trap_cause_o
);

  state_e             r_state;
  logic [CNT_W-1:0]   r_flush_cnt;
  logic [XLEN-1:0]    r_target;
  logic [CAUSE_W-1:0] r_cause;
  logic               r_flush;
  logic               r_valid;
  logic               r_trap;
  logic [CAUSE_W-1:0] w_cause;
  logic [STALL_W-1:0] w_stall_req;

  localparam logic [CNT_W-1:0] FLUSH_LOAD = CNT_W'(FLUSH_CYCLES - 1);

  pipe_ctrl_cause_enc u_cause_enc (
    .exc_i   (exception_i),
    .cause_o (w_cause)
  );

  always_comb begin
    w_stall_req = '0;
    if (stallreq_mem_i)     w_stall_req = stall_upto(STG_MEM);
    else if (stallreq_ex_i) w_stall_req = stall_upto(STG_EX);
    else if (stallreq_id_i) w_stall_req = stall_upto(STG_ID);
    else if (stallreq_if_i) w_stall_req = stall_upto(STG_IF);
    // A flush in progress overrides every hold request.
    stall_o = (n_rst_i && (r_state == ST_IDLE)) ? w_stall_req : '0;
  end

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_state     <= ST_IDLE;
      r_flush_cnt <= '0;
      r_target    <= '0;
      r_cause     <= '0;
      r_flush     <= 1'b0;
      r_valid     <= 1'b0;
      r_trap      <= 1'b0;
    end else begin
      r_trap <= 1'b0;
      case (r_state)
        ST_IDLE: begin
          if (|exception_i) begin
            r_target    <= mtvec_i;
            r_cause     <= w_cause;
            r_trap      <= 1'b1;
            r_flush     <= 1'b1;
            r_flush_cnt <= FLUSH_LOAD;
            r_state     <= ST_FLUSH;
          end else if (mret_i) begin
            r_target    <= mepc_i;
            r_flush     <= 1'b1;
            r_flush_cnt <= FLUSH_LOAD;
            r_state     <= ST_FLUSH;
          end
        end
        ST_FLUSH: begin
          if (r_flush_cnt == '0) begin
            r_valid <= 1'b1;
            r_state <= ST_REDIRECT;
          end else begin
            r_flush_cnt <= r_flush_cnt - 1'b1;
          end
        end
        ST_REDIRECT: begin
          if (pc_ack_i) begin
            r_flush <= 1'b0;
            r_valid <= 1'b0;
            r_state <= ST_IDLE;
          end
        end
        default: begin
          r_flush <= 1'b0;
          r_valid <= 1'b0;
          r_state <= ST_IDLE;
        end
      endcase
    end
  end

  assign flush_o        = r_flush;
  assign new_pc_valid_o = r_valid;
  assign new_pc_o       = r_target;
  assign trap_o         = r_trap;
  assign trap_cause_o   = r_cause;

`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] r_stall_cycles;
  logic [31:0] r_flush_cycles;

  always_ff @(posedge clk_i or negedge n_rst_i) begin
    if (!n_rst_i) begin
      r_stall_cycles <= '0;
      r_flush_cycles <= '0;
    end else begin
      if (|stall_o) r_stall_cycles <= r_stall_cycles + 32'd1;
      if (r_flush)  r_flush_cycles <= r_flush_cycles + 32'd1;
    end
  end

  assign stall_cycles_o = r_stall_cycles;
  assign flush_cycles_o = r_flush_cycles;
`endif

endmodule

// File: tb/tb_pipe_ctrl.sv
// Directed bench for pipe_ctrl: stall-merge vector table plus hand-written
// trap, mret, handshake and reset sequences on FLUSH_CYCLES=1 and 3 instances.
module tb_pipe_ctrl;
  import pipe_ctrl_pkg::*;

  logic        clk = 1'b0;
  logic        n_rst;
  logic        rq_if, rq_id, rq_ex, rq_mem;
  logic [31:0] exception;
  logic        mret;
  logic [31:0] mtvec, mepc;
  logic        pc_ack;

  logic [5:0]  stall_a, stall_b;
  logic        flush_a, flush_b, valid_a, valid_b, trap_a, trap_b;
  logic [31:0] pc_a, pc_b;
  logic [4:0]  cause_a, cause_b;
`ifdef PIPE_CTRL_PERF_CNT_EN
  logic [31:0] scnt_a, fcnt_a, scnt_b, fcnt_b;
`endif

  int n_vec = 0;
  int n_err = 0;

  always #5 clk = ~clk;

  pipe_ctrl #(.FLUSH_CYCLES(1), .XLEN(32)) dut (
    .clk_i(clk), .n_rst_i(n_rst),
    .stallreq_if_i(rq_if), .stallreq_id_i(rq_id),
    .stallreq_ex_i(rq_ex), .stallreq_mem_i(rq_mem),
    .exception_i(exception), .mret_i(mret),
    .mtvec_i(mtvec), .mepc_i(mepc), .pc_ack_i(pc_ack),
    .stall_o(stall_a), .flush_o(flush_a), .new_pc_valid_o(valid_a),
    .new_pc_o(pc_a), .trap_o(trap_a),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cycles_o(scnt_a), .flush_cycles_o(fcnt_a),
`endif
    .trap_cause_o(cause_a)
  );

  pipe_ctrl #(.FLUSH_CYCLES(3), .XLEN(32)) dut3 (
    .clk_i(clk), .n_rst_i(n_rst),
    .stallreq_if_i(rq_if), .stallreq_id_i(rq_id),
    .stallreq_ex_i(rq_ex), .stallreq_mem_i(rq_mem),
    .exception_i(exception), .mret_i(mret),
    .mtvec_i(mtvec), .mepc_i(mepc), .pc_ack_i(pc_ack),
    .stall_o(stall_b), .flush_o(flush_b), .new_pc_valid_o(valid_b),
    .new_pc_o(pc_b), .trap_o(trap_b),
`ifdef PIPE_CTRL_PERF_CNT_EN
    .stall_cycles_o(scnt_b), .flush_cycles_o(fcnt_b),
`endif
    .trap_cause_o(cause_b)
  );

  typedef struct {
    logic       r_if, r_id, r_ex, r_mem;
    logic [5:0] exp;
  } stall_vec_t;

  stall_vec_t tbl[10];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_vec++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic pulse_reset();
    @(negedge clk);
    n_rst = 1'b0;
    #2;
    n_rst = 1'b1;
    #1;
  endtask

  initial begin
    tbl[0] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[1] = '{1'b0, 1'b1, 1'b0, 1'b0, 6'b000111};
    tbl[2] = '{1'b0, 1'b1, 1'b0, 1'b1, 6'b011111};
    tbl[3] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};
    tbl[4] = '{1'b1, 1'b0, 1'b0, 1'b0, 6'b000011};
    tbl[5] = '{1'b0, 1'b0, 1'b1, 1'b0, 6'b001111};
    tbl[6] = '{1'b1, 1'b1, 1'b1, 1'b0, 6'b001111};
    tbl[7] = '{1'b1, 1'b1, 1'b0, 1'b0, 6'b000111};
    tbl[8] = '{1'b1, 1'b1, 1'b1, 1'b1, 6'b011111};
    tbl[9] = '{1'b0, 1'b0, 1'b0, 1'b0, 6'b000000};

    n_rst = 1'b0;
    rq_if = 0; rq_id = 0; rq_ex = 0; rq_mem = 1;
    exception = '0; mret = 0; pc_ack = 0;
    mtvec = 32'h8000_0100; mepc = 32'h0000_2040;
    #2;
    chk("rst_stall", {26'd0, stall_a}, 32'h0);
    chk("rst_flush", {31'd0, flush_a}, 32'h0);
    chk("rst_valid", {31'd0, valid_a}, 32'h0);
    chk("rst_pc",    pc_a, 32'h0);
    chk("rst_trap",  {31'd0, trap_a}, 32'h0);
    chk("rst_cause", {27'd0, cause_a}, 32'h0);
    rq_mem = 0;
    @(negedge clk);
    n_rst = 1'b1;
    tick();

    // Stall merge table
    for (int i = 0; i < 10; i++) begin
      rq_if = tbl[i].r_if; rq_id = tbl[i].r_id;
      rq_ex = tbl[i].r_ex; rq_mem = tbl[i].r_mem;
      #1;
      chk($sformatf("stall_vec%0d", i), {26'd0, stall_a}, {26'd0, tbl[i].exp});
      tick();
    end

    // pc_ack in IDLE has no effect
    pc_ack = 1;
    tick();
    chk("idle_ack_valid", {31'd0, valid_a}, 32'h0);
    chk("idle_ack_flush", {31'd0, flush_a}, 32'h0);
    pc_ack = 0;

    // Trap: exception bit 2, FLUSH_CYCLES=1
    exception = 32'h0000_0004; mtvec = 32'h8000_0100;
    tick();                                   // T+1
    exception = '0;
    chk("trap_pulse", {31'd0, trap_a}, 32'h1);
    chk("trap_cause", {27'd0, cause_a}, 32'd2);
    chk("trap_flush", {31'd0, flush_a}, 32'h1);
    chk("trap_novalid", {31'd0, valid_a}, 32'h0);
    tick();                                   // T+2
    chk("trap_pulse_end", {31'd0, trap_a}, 32'h0);
    chk("trap_valid", {31'd0, valid_a}, 32'h1);
    chk("trap_pc", pc_a, 32'h8000_0100);
    tick();                                   // T+3
    chk("trap_hold_valid", {31'd0, valid_a}, 32'h1);
    tick();                                   // T+4
    chk("trap_hold_pc", pc_a, 32'h8000_0100);
    pc_ack = 1;
    tick();                                   // T+5
    pc_ack = 0;
    chk("trap_done_flush", {31'd0, flush_a}, 32'h0);
    chk("trap_done_valid", {31'd0, valid_a}, 32'h0);

    // mret path
    mret = 1; mepc = 32'h0000_2040;
    tick();
    mret = 0;
    chk("mret_notrap", {31'd0, trap_a}, 32'h0);
    chk("mret_cause_kept", {27'd0, cause_a}, 32'd2);
    chk("mret_flush", {31'd0, flush_a}, 32'h1);
    tick();
    chk("mret_valid", {31'd0, valid_a}, 32'h1);
    chk("mret_pc", pc_a, 32'h0000_2040);
    pc_ack = 1;
    tick();
    pc_ack = 0;
    chk("mret_done", {31'd0, valid_a}, 32'h0);

    // Exception and mret together: exception wins
    exception = 32'h0000_0800; mret = 1;
    tick();
    exception = '0; mret = 0;
    chk("both_trap", {31'd0, trap_a}, 32'h1);
    chk("both_cause", {27'd0, cause_a}, 32'd11);
    // ack during FLUSH is ignored; still high when valid rises -> 1-cycle REDIRECT
    pc_ack = 1;
    tick();
    chk("both_valid", {31'd0, valid_a}, 32'h1);
    chk("both_pc", pc_a, 32'h8000_0100);
    tick();
    pc_ack = 0;
    chk("fast_ack_valid", {31'd0, valid_a}, 32'h0);
    chk("fast_ack_flush", {31'd0, flush_a}, 32'h0);

    // FLUSH_CYCLES=3 with EX stall held high throughout
    pulse_reset();
    rq_ex = 1;
    #1;
    chk("f3_pre_stall", {26'd0, stall_b}, 32'h0f);
    exception = 32'h0000_0001; mtvec = 32'h8000_0200;
    tick();
    chk("f3_trap", {31'd0, trap_b}, 32'h1);
    chk("f3_cause", {27'd0, cause_b}, 32'd0);
    for (int c = 1; c <= 3; c++) begin
      if (c > 1) tick();
      chk($sformatf("f3_flush%0d", c), {31'd0, flush_b}, 32'h1);
      chk($sformatf("f3_novalid%0d", c), {31'd0, valid_b}, 32'h0);
      chk($sformatf("f3_stall%0d", c), {26'd0, stall_b}, 32'h0);
      if (c > 1) chk($sformatf("f3_notrap%0d", c), {31'd0, trap_b}, 32'h0);
    end
    exception = '0;
    tick();
    chk("f3_valid", {31'd0, valid_b}, 32'h1);
    chk("f3_pc", pc_b, 32'h8000_0200);
    chk("f3_redir_stall", {26'd0, stall_b}, 32'h0);
    tick();
    chk("f3_hold_valid", {31'd0, valid_b}, 32'h1);
    chk("f3_hold_flush", {31'd0, flush_b}, 32'h1);
    pc_ack = 1;
    tick();
    pc_ack = 0;
    chk("f3_done_valid", {31'd0, valid_b}, 32'h0);
    chk("f3_done_stall", {26'd0, stall_b}, 32'h0f);
    rq_ex = 0;

    // Reset in REDIRECT without ack, then fresh sequence
    exception = 32'h0000_0040; mtvec = 32'h8000_0300;
    tick();
    exception = '0;
    tick();
    chk("rr_in_redir", {31'd0, valid_a}, 32'h1);
    n_rst = 1'b0;
    #1;
    chk("rr_valid", {31'd0, valid_a}, 32'h0);
    chk("rr_flush", {31'd0, flush_a}, 32'h0);
    chk("rr_pc", pc_a, 32'h0);
    chk("rr_cause", {27'd0, cause_a}, 32'h0);
    @(negedge clk);
    n_rst = 1'b1;
    tick();
    chk("rr_idle_valid", {31'd0, valid_a}, 32'h0);
    chk("rr_idle_flush", {31'd0, flush_a}, 32'h0);
    exception = 32'h0000_0030; mtvec = 32'h8000_0400;
    tick();
    exception = '0;
    chk("rr_new_trap", {31'd0, trap_a}, 32'h1);
    chk("rr_new_cause", {27'd0, cause_a}, 32'd4);
    tick();
    chk("rr_new_pc", pc_a, 32'h8000_0400);
    chk("rr_new_valid", {31'd0, valid_a}, 32'h1);
    pc_ack = 1;
    tick();
    pc_ack = 0;

    $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
    $finish;
  end

endmodule
